branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have ports CLK (in, 1, sole clock) and Init_n (in, 1, asynchronous active-low reset).
REQ-002 The block SHALL have ports Start (in, 1, run request), Instr (in, 9, instruction at current PC) and PC (in, 8, current fetch PC).
REQ-003 The block SHALL have ports CmpA and CmpB (in, 8 each, compare operands).
REQ-004 The block SHALL have ports FetchInit (out, 1, PC-clear pulse to fetch), Branch (out, 1, take relative branch) and Target (out, 5, two's-complement offset, -16..+15).
REQ-005 The block SHALL have ports Halt (out, 1, freeze PC), Done (out, 1, program halted normally) and Err (out, 1, illegal branch detected).
REQ-006 The block SHALL have ports CycleCnt (out, 16, RUN cycles) and TakenCnt (out, 8, branches taken).

Function
REQ-007 The FSM SHALL have states IDLE, LAUNCH and RUN.
REQ-008 The FSM SHALL have a fourth state, HALTED.
REQ-009 IDLE: Halt=1, Branch=0; Start=1 -> LAUNCH.
REQ-010 LAUNCH: lasts exactly 1 cycle; FetchInit=1, Halt=0, Branch=0; clears Z, Done, Err and both counters; -> RUN.
REQ-011 RUN: Halt=0 unless a halt condition is decoded (REQ-015/016); Start is ignored.
REQ-012 Decode, op=Instr[8:5], off=Instr[4:0]: 4'b1100 = CMP, 4'b1101 = BZ, 4'b1110 = BNZ, 4'b1111 with off=5'b11111 = HLT; all other encodings = no-op for this block.
REQ-013 CMP SHALL set register Z to (CmpA==CmpB) on the clock edge ending that cycle; a BZ/BNZ in the very next cycle sees the new Z.
REQ-014 BZ (Z=1) or BNZ (Z=0) SHALL be taken: Branch=1 and Target=off combinationally in the same cycle, so fetch applies the branch on that edge.
REQ-014a An untaken branch SHALL give Branch=0; Target=off always in RUN, else 0.
REQ-015 Legality: a taken branch SHALL be legal only if off!=0 and PC+sext(off), computed 9-bit, lies in 0..255.
REQ-015a An illegal taken branch SHALL give Branch=0, Halt=1 that cycle, set Err, -> HALTED.
REQ-016 HLT in RUN SHALL assert Halt=1 combinationally that cycle, set Done, -> HALTED.
REQ-017 HALTED: Halt=1, Branch=0, Done/Err held; Start=1 -> LAUNCH.
REQ-018 Done and Err SHALL never both be 1.
REQ-019 CycleCnt SHALL increment by 1 every RUN cycle, including the HLT/error cycle, and saturate at 16'hFFFF.
REQ-020 TakenCnt SHALL increment on each legal taken branch and saturate at 8'hFF.
REQ-021 Both counters SHALL hold their values in IDLE/HALTED.
REQ-022 Instr, PC, CmpA and CmpB SHALL be ignored outside RUN.

Reset
REQ-023 Init_n=0 SHALL force, asynchronously and at any time including mid-RUN: state=IDLE, Z=0, Done=0, Err=0, CycleCnt=0, TakenCnt=0.
REQ-024 While Init_n=0 the combinational outputs SHALL be FetchInit=0, Branch=0, Target=0, Halt=1.
REQ-025 Release of Init_n SHALL be followed by IDLE until Start.

Configuration
REQ-026 Macro BRANCH_CTRL_STATS_EN defined: CycleCnt and TakenCnt SHALL be implemented per REQ-019..021.
REQ-027 Macro BRANCH_CTRL_STATS_EN undefined: no counter registers SHALL be synthesized; CycleCnt=0 and TakenCnt=0 constantly; all other behaviour unchanged.

Verification
REQ-028 Reset/launch: Init_n low mid-RUN -> Halt=1, IDLE, counters 0; Start=1 -> FetchInit=1 for exactly 1 cycle, then RUN.
REQ-029 Compare/branch: CMP with CmpA=CmpB=8'h3C, then BZ off=5'b11101 at PC=20 -> Branch=1, Target=5'b11101; BNZ next -> Branch=0.
REQ-030 Illegal: taken BZ at PC=2 with off=-3 -> Branch=0, Halt=1, Err=1, HALTED.
REQ-031 Illegal: taken BNZ at PC=250 with off=+10 -> Branch=0, Halt=1, Err=1, HALTED.
REQ-032 Illegal: taken branch with off=0 -> Branch=0, Halt=1, Err=1, HALTED.
REQ-033 Halt/restart: HLT (9'b1111_11111) after 7 RUN cycles and 3 taken branches -> Halt=1, Done=1, CycleCnt=7, TakenCnt=3; Start -> counters and Done clear.
REQ-034 Saturation (STATS_EN): 70000 RUN cycles -> CycleCnt=16'hFFFF; 300 taken branches -> TakenCnt=8'hFF.
REQ-035 Saturation (STATS_EN undefined): same stimulus as REQ-034 -> CycleCnt=0, TakenCnt=0.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Branch controller bus: run request, instruction/PC/operand inputs,
// fetch-control outputs and run statistics (master = sequencer, slave = branch_ctrl).
interface branch_ctrl_if;
   logic        Start;
   logic [8:0]  Instr;
   logic [7:0]  PC;
   logic [7:0]  CmpA;
   logic [7:0]  CmpB;
   logic        FetchInit;
   logic        Branch;
   logic [4:0]  Target;
   logic        Halt;
   logic        Done;
   logic        Err;
   logic [15:0] CycleCnt;
   logic [7:0]  TakenCnt;

   modport master (
      output Start, Instr, PC, CmpA, CmpB,
      input  FetchInit, Branch, Target, Halt,
      input  Done, Err, CycleCnt, TakenCnt
   );

   modport slave (
      input  Start, Instr, PC, CmpA, CmpB,
      output FetchInit, Branch, Target, Halt,
      output Done, Err, CycleCnt, TakenCnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: IDLE/LAUNCH/RUN/HALTED sequencer deciding relative branches,
// halts and illegal-branch errors. Ports: CLK, Init_n (async low), bus (slave).
// Macro BRANCH_CTRL_STATS_EN enables the CycleCnt/TakenCnt counters (else tied 0).
module branch_ctrl (
   input  logic       CLK,
   input  logic       Init_n,
   branch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HALTED} state_t;

   state_t state, nxt;
   logic   z, done, err;
   logic   fetch_init, halt, set_done, set_err, legal_taken;
   logic [4:0] target;

   logic [3:0] op;
   logic [4:0] off;
   logic [8:0] dest;
   logic       is_cmp, is_bz, is_bnz, is_hlt, taken, legal;

   assign op     = bus.Instr[8:5];
   assign off    = bus.Instr[4:0];
   assign is_cmp = (op == 4'b1100);
   assign is_bz  = (op == 4'b1101);
   assign is_bnz = (op == 4'b1110);
   assign is_hlt = (op == 4'b1111) && (off == 5'b11111);
   assign taken  = (is_bz && z) || (is_bnz && !z);

   // 9-bit destination: bit 8 set means the target left 0..255
   assign dest  = {1'b0, bus.PC} + {{4{off[4]}}, off};
   assign legal = (off != 5'd0) && !dest[8];

   always_comb begin
      nxt         = state;
      fetch_init  = 1'b0;
      halt        = 1'b1;
      target      = 5'd0;
      set_done    = 1'b0;
      set_err     = 1'b0;
      legal_taken = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.Start) nxt = LAUNCH;
         end
         LAUNCH: begin
            fetch_init = 1'b1;
            halt       = 1'b0;
            nxt        = RUN;
         end
         RUN: begin
            halt   = 1'b0;
            target = off;
            if (is_hlt) begin
               halt     = 1'b1;
               set_done = 1'b1;
               nxt      = HALTED;
            end else if (taken && !legal) begin
               halt    = 1'b1;
               set_err = 1'b1;
               nxt     = HALTED;
            end else if (taken) begin
               legal_taken = 1'b1;
            end
         end
         HALTED: begin
            if (bus.Start) nxt = LAUNCH;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         state <= IDLE;
         z     <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= nxt;
         if (state == LAUNCH) begin
            z    <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
         end else begin
            if (state == RUN && is_cmp) z <= (bus.CmpA == bus.CmpB);
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
         end
      end
   end

`ifdef BRANCH_CTRL_STATS_EN
   logic [15:0] cyc_cnt;
   logic [7:0]  tkn_cnt;

   always_ff @(posedge CLK or negedge Init_n) begin
      if (!Init_n) begin
         cyc_cnt <= 16'd0;
         tkn_cnt <= 8'd0;
      end else if (state == LAUNCH) begin
         cyc_cnt <= 16'd0;
         tkn_cnt <= 8'd0;
      end else begin
         if (state == RUN && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
         if (legal_taken && tkn_cnt != 8'hFF) tkn_cnt <= tkn_cnt + 8'd1;
      end
   end

   assign bus.CycleCnt = cyc_cnt;
   assign bus.TakenCnt = tkn_cnt;
`else
   assign bus.CycleCnt = 16'd0;
   assign bus.TakenCnt = 8'd0;
`endif

   assign bus.FetchInit = fetch_init;
   assign bus.Branch    = legal_taken;
   assign bus.Target    = target;
   assign bus.Halt      = halt;
   assign bus.Done      = done;
   assign bus.Err       = err;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl: reset, compare/branch,
// illegal branches, halt/restart and counter saturation.
module tb_branch_ctrl;
   logic CLK;
   logic Init_n;
   int   errs;
   int   chks;

   branch_ctrl_if bus ();

   branch_ctrl dut (
      .CLK   (CLK),
      .Init_n(Init_n),
      .bus   (bus.slave)
   );

`ifdef BRANCH_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [8:0] NOP = 9'h000;
   localparam logic [3:0] OP_CMP = 4'b1100;
   localparam logic [3:0] OP_BZ  = 4'b1101;
   localparam logic [3:0] OP_BNZ = 4'b1110;
   localparam logic [8:0] HLT = 9'b1111_11111;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // drive one instruction slot at the falling edge; outputs settle by +1
   task automatic cyc(input logic [8:0] ins, input logic [7:0] pc,
                      input logic [7:0] a, input logic [7:0] b);
      @(negedge CLK);
      bus.Instr = ins;
      bus.PC    = pc;
      bus.CmpA  = a;
      bus.CmpB  = b;
      #1;
   endtask

   task automatic launch;
      @(negedge CLK);
      bus.Start = 1'b1;
      bus.Instr = NOP;
      @(negedge CLK);
      bus.Start = 1'b0;
      #1;
      if (bus.FetchInit !== 1'b1 || bus.Halt !== 1'b0) begin
         errs++;
         $display("FAIL launch fi=%b halt=%b exp fi=1 halt=0", bus.FetchInit, bus.Halt);
      end
      chks++;
   endtask

   task automatic test_reset;
      Init_n = 1'b0;
      bus.Start = 1'b0;
      bus.Instr = NOP; bus.PC = 8'd0; bus.CmpA = 8'd0; bus.CmpB = 8'd0;
      #12;
      if ({bus.Halt, bus.Branch, bus.FetchInit, bus.Target} !== {3'b100, 5'd0}) begin
         errs++;
         $display("FAIL rst_outs h/b/fi/t=%b%b%b/%0d exp 100/0", bus.Halt, bus.Branch, bus.FetchInit, bus.Target);
      end
      chks++;
      if ({bus.Done, bus.Err, bus.CycleCnt, bus.TakenCnt} !== 26'd0) begin
         errs++;
         $display("FAIL rst_regs d=%b e=%b cc=%0d tc=%0d exp 0", bus.Done, bus.Err, bus.CycleCnt, bus.TakenCnt);
      end
      chks++;
      @(negedge CLK);
      Init_n = 1'b1;
      cyc(9'b1101_00001, 8'd10, 8'd1, 8'd1);
      cyc(NOP, 8'd10, 8'd1, 8'd1);
      if (bus.Halt !== 1'b1 || bus.FetchInit !== 1'b0 || bus.Target !== 5'd0) begin
         errs++;
         $display("FAIL idle_hold halt=%b fi=%b t=%0d exp 1/0/0", bus.Halt, bus.FetchInit, bus.Target);
      end
      chks++;
   endtask

   task automatic test_reset_launch;
      launch();
      cyc(NOP, 8'd0, 8'd0, 8'd0);
      if (bus.FetchInit !== 1'b0 || bus.Halt !== 1'b0) begin
         errs++;
         $display("FAIL run_entry fi=%b halt=%b exp 0/0", bus.FetchInit, bus.Halt);
      end
      chks++;
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'd0, 8'd0);
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'd0, 8'd0);
      if (bus.Branch !== 1'b1) begin
         errs++;
         $display("FAIL pre_rst_branch got=%b exp=1", bus.Branch);
      end
      chks++;
      #2;
      Init_n = 1'b0;
      #1;
      if ({bus.Halt, bus.Branch, bus.FetchInit, bus.Target} !== {3'b100, 5'd0}) begin
         errs++;
         $display("FAIL midrun_rst h/b/fi/t=%b%b%b/%0d exp 100/0", bus.Halt, bus.Branch, bus.FetchInit, bus.Target);
      end
      chks++;
      if (bus.CycleCnt !== 16'd0 || bus.TakenCnt !== 8'd0) begin
         errs++;
         $display("FAIL midrun_cnt cc=%0d tc=%0d exp 0/0", bus.CycleCnt, bus.TakenCnt);
      end
      chks++;
      @(negedge CLK);
      Init_n = 1'b1;
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'd0, 8'd0);
      if (bus.Halt !== 1'b1 || bus.Branch !== 1'b0) begin
         errs++;
         $display("FAIL post_rst_idle halt=%b br=%b exp 1/0", bus.Halt, bus.Branch);
      end
      chks++;
   endtask

   task automatic test_branch;
      launch();
      cyc({OP_CMP, 5'd0}, 8'd19, 8'h3C, 8'h3C);
      if (bus.Branch !== 1'b0 || bus.Halt !== 1'b0) begin
         errs++;
         $display("FAIL cmp_cycle br=%b halt=%b exp 0/0", bus.Branch, bus.Halt);
      end
      chks++;
      cyc({OP_BZ, 5'b11101}, 8'd20, 8'h00, 8'h01);
      if (bus.Branch !== 1'b1 || bus.Target !== 5'b11101) begin
         errs++;
         $display("FAIL bz_taken br=%b t=%b exp 1/11101", bus.Branch, bus.Target);
      end
      chks++;
      cyc({OP_BNZ, 5'b00110}, 8'd17, 8'h00, 8'h01);
      if (bus.Branch !== 1'b0 || bus.Target !== 5'b00110 || bus.Halt !== 1'b0) begin
         errs++;
         $display("FAIL bnz_untaken br=%b t=%b halt=%b exp 0/00110/0", bus.Branch, bus.Target, bus.Halt);
      end
      chks++;
      cyc({OP_CMP, 5'd0}, 8'd18, 8'h3C, 8'h3D);
      cyc({OP_BZ, 5'd4}, 8'd19, 8'h3C, 8'h3C);
      if (bus.Branch !== 1'b0) begin
         errs++;
         $display("FAIL bz_untaken br=%b exp 0", bus.Branch);
      end
      chks++;
      cyc({OP_BNZ, 5'd4}, 8'd20, 8'h3C, 8'h3C);
      if (bus.Branch !== 1'b1 || bus.Target !== 5'd4) begin
         errs++;
         $display("FAIL bnz_taken br=%b t=%0d exp 1/4", bus.Branch, bus.Target);
      end
      chks++;
      cyc(9'b1111_00000, 8'd24, 8'h00, 8'h00);
      if (bus.Halt !== 1'b0 || bus.Branch !== 1'b0) begin
         errs++;
         $display("FAIL op15_nop halt=%b br=%b exp 0/0", bus.Halt, bus.Branch);
      end
      chks++;
      cyc({OP_BNZ, 5'b10000}, 8'd16, 8'h00, 8'h00);
      if (bus.Branch !== 1'b1 || bus.Halt !== 1'b0) begin
         errs++;
         $display("FAIL edge_to_0 br=%b halt=%b exp 1/0", bus.Branch, bus.Halt);
      end
      chks++;
      cyc(HLT, 8'd0, 8'h00, 8'h00);
   endtask

   task automatic illegal_case(input string nm, input logic [8:0] ins, input logic [7:0] pc,
                               input bit need_z);
      launch();
      if (need_z) cyc({OP_CMP, 5'd0}, 8'd0, 8'h55, 8'h55);
      cyc(ins, pc, 8'h00, 8'h01);
      if (bus.Branch !== 1'b0 || bus.Halt !== 1'b1) begin
         errs++;
         $display("FAIL %s br=%b halt=%b exp 0/1", nm, bus.Branch, bus.Halt);
      end
      chks++;
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'h00, 8'h01);
      if (bus.Err !== 1'b1 || bus.Done !== 1'b0 || bus.Halt !== 1'b1 || bus.Branch !== 1'b0) begin
         errs++;
         $display("FAIL %s_halted err=%b done=%b halt=%b br=%b exp 1/0/1/0", nm, bus.Err, bus.Done, bus.Halt, bus.Branch);
      end
      chks++;
   endtask

   task automatic test_illegal;
      illegal_case("ill_neg", {OP_BZ, 5'b11101}, 8'd2, 1'b1);
      illegal_case("ill_pos", {OP_BNZ, 5'b01010}, 8'd250, 1'b0);
      illegal_case("ill_zero", {OP_BNZ, 5'b00000}, 8'd50, 1'b0);
   endtask

   task automatic test_halt;
      launch();
      cyc(NOP, 8'd0, 8'h00, 8'h00);
      if (bus.Err !== 1'b0) begin
         errs++;
         $display("FAIL err_clear got=%b exp=0", bus.Err);
      end
      chks++;
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'h00, 8'h00);
      bus.Start = 1'b1;
      cyc(NOP, 8'd11, 8'h00, 8'h00);
      bus.Start = 1'b0;
      cyc({OP_BNZ, 5'd2}, 8'd10, 8'h00, 8'h00);
      if (bus.FetchInit !== 1'b0 || bus.Branch !== 1'b1) begin
         errs++;
         $display("FAIL start_ignored fi=%b br=%b exp 0/1", bus.FetchInit, bus.Branch);
      end
      chks++;
      cyc({OP_CMP, 5'd0}, 8'd12, 8'h07, 8'h07);
      cyc({OP_BZ, 5'b11111}, 8'd30, 8'h00, 8'h00);
      cyc(HLT, 8'd29, 8'h00, 8'h00);
      if (bus.Halt !== 1'b1 || bus.Branch !== 1'b0) begin
         errs++;
         $display("FAIL hlt_cycle halt=%b br=%b exp 1/0", bus.Halt, bus.Branch);
      end
      chks++;
      cyc({OP_BNZ, 5'd1}, 8'd10, 8'h00, 8'h00);
      cyc({OP_CMP, 5'd0}, 8'd10, 8'h00, 8'h00);
      if (bus.Done !== 1'b1 || bus.Err !== 1'b0 || bus.Halt !== 1'b1) begin
         errs++;
         $display("FAIL halted done=%b err=%b halt=%b exp 1/0/1", bus.Done, bus.Err, bus.Halt);
      end
      chks++;
      if (bus.CycleCnt !== (STATS ? 16'd7 : 16'd0) || bus.TakenCnt !== (STATS ? 8'd3 : 8'd0)) begin
         errs++;
         $display("FAIL halt_counts cc=%0d tc=%0d exp %0d/%0d", bus.CycleCnt, bus.TakenCnt,
                  STATS ? 7 : 0, STATS ? 3 : 0);
      end
      chks++;
      launch();
      cyc(NOP, 8'd0, 8'h00, 8'h00);
      if (bus.Done !== 1'b0 || bus.CycleCnt !== 16'd0 || bus.TakenCnt !== 8'd0) begin
         errs++;
         $display("FAIL restart_clear done=%b cc=%0d tc=%0d exp 0/0/0", bus.Done, bus.CycleCnt, bus.TakenCnt);
      end
      chks++;
      cyc(HLT, 8'd0, 8'h00, 8'h00);
   endtask

   task automatic test_saturation;
      launch();
      for (int i = 0; i < 70000; i++) cyc(NOP, 8'd0, 8'h00, 8'h00);
      cyc(NOP, 8'd0, 8'h00, 8'h00);
      if (bus.CycleCnt !== (STATS ? 16'hFFFF : 16'd0)) begin
         errs++;
         $display("FAIL cyc_sat got=%h exp=%h", bus.CycleCnt, STATS ? 16'hFFFF : 16'h0);
      end
      chks++;
      cyc(HLT, 8'd0, 8'h00, 8'h00);
      launch();
      for (int i = 0; i < 300; i++) cyc({OP_BNZ, 5'd1}, 8'd100, 8'h00, 8'h00);
      cyc(NOP, 8'd0, 8'h00, 8'h00);
      if (bus.TakenCnt !== (STATS ? 8'hFF : 8'd0)) begin
         errs++;
         $display("FAIL tkn_sat got=%h exp=%h", bus.TakenCnt, STATS ? 8'hFF : 8'h0);
      end
      chks++;
      if (bus.CycleCnt !== (STATS ? 16'd300 : 16'd0)) begin
         errs++;
         $display("FAIL cyc_300 got=%0d exp=%0d", bus.CycleCnt, STATS ? 300 : 0);
      end
      chks++;
   endtask

   initial begin
      errs = 0;
      chks = 0;
      test_reset();
      test_reset_launch();
      test_branch();
      test_illegal();
      test_halt();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
